multiplicador_secuencial: RTL and testbench

- Multi-cycle signed shift-add multiplier.
- Uses the same operand/Start/Done handshake as the existing sequential divider, so the control unit drives both with identical sequencing logic.
- Sits beside the divider in the datapath; driven by the control unit and checked by the same interface-based bench style.

---
 rtl/mult_pkg.sv | 20 ++
 rtl/multiplicador_secuencial.sv | 140 ++++++++++++++
 tb/tb_multiplicador_secuencial.sv | 138 +++++++++++++
 3 files changed

// File: rtl/mult_pkg.sv
// rtl/mult_pkg.sv - FSM states, default width and magnitude helper for the sequential multiplier
package mult_pkg;

   // FSM states shared by the multiplier and its testbench
   typedef enum logic [1:0] {
      IDLE,
      CALC,
      SIGN,
      FIN
   } mult_state_t;

   // Default operand width; the product is twice this
   localparam int MULT_WIDTH = 32;

   // Unsigned magnitude of a two's complement value; the most negative value maps to 0x80..0
   function automatic logic [MULT_WIDTH-1:0] abs_val(input logic [MULT_WIDTH-1:0] x);
      return x[MULT_WIDTH-1] ? (~x + 1'b1) : x;
   endfunction

endpackage

// File: rtl/multiplicador_secuencial.sv
// rtl/multiplicador_secuencial.sv - multi-cycle signed shift-add multiplier (optional MULT_EARLY_EXIT_EN)
module multiplicador_secuencial
   import mult_pkg::*;
#(
   parameter int tamanyo = MULT_WIDTH
)
(
   input  logic                   CLK,
   input  logic                   RSTa,
   input  logic                   Start,
   input  logic [tamanyo-1:0]     A,
   input  logic [tamanyo-1:0]     B,
   output logic                   Busy,
   output logic                   Done,
   output logic [2*tamanyo-1:0]   P
);

   localparam int CW = $clog2(tamanyo + 1);

   mult_state_t            state;
   mult_state_t            state_nxt;

   logic                   sign_q;
   logic [tamanyo-1:0]     mag_a;
   logic [tamanyo-1:0]     mag_b;
   logic [2*tamanyo-1:0]   acc;
   logic [CW-1:0]          count;
   logic [2*tamanyo-1:0]   p_q;

   logic [tamanyo-1:0]     a_mag;
   logic [tamanyo-1:0]     b_mag;
   logic [2*tamanyo-1:0]   addend;
   logic                   calc_last;

   // Operand magnitudes: package helper at its native width, inline form otherwise
   generate
      if (tamanyo == MULT_WIDTH) begin : g_abs_pkg
         assign a_mag = abs_val(A);
         assign b_mag = abs_val(B);
      end else begin : g_abs_inline
         assign a_mag = A[tamanyo-1] ? (~A + 1'b1) : A;
         assign b_mag = B[tamanyo-1] ? (~B + 1'b1) : B;
      end
   endgenerate

   // Partial product for the current iteration, multiplicand shifted by the bit position
   assign addend = {{tamanyo{1'b0}}, mag_a} << count;

`ifdef MULT_EARLY_EXIT_EN
   // Stop as soon as no set multiplier bits remain after this iteration
   assign calc_last = (count == CW'(tamanyo - 1)) || (mag_b[tamanyo-1:1] == '0);
`else
   // Fixed iteration count keeps the latency deterministic
   assign calc_last = (count == CW'(tamanyo - 1));
`endif

   // State register; reset abandons any operation in flight
   always_ff @(posedge CLK or posedge RSTa) begin
      if (RSTa) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Next-state decode and handshake outputs
   always_comb begin
      state_nxt = state;
      Busy      = 1'b0;
      Done      = 1'b0;
      case (state)
         IDLE: begin
            if (Start) begin
`ifdef MULT_EARLY_EXIT_EN
               state_nxt = (b_mag == '0) ? SIGN : CALC;
`else
               state_nxt = CALC;
`endif
            end
         end
         CALC: begin
            Busy = 1'b1;
            if (calc_last) begin
               state_nxt = SIGN;
            end
         end
         SIGN: begin
            Busy      = 1'b1;
            state_nxt = FIN;
         end
         FIN: begin
            Done      = 1'b1;
            state_nxt = IDLE;
         end
         default: begin
            state_nxt = IDLE;
         end
      endcase
   end

   // Datapath: latch operands on accept, shift-add while calculating, apply sign at the end
   always_ff @(posedge CLK or posedge RSTa) begin
      if (RSTa) begin
         sign_q <= 1'b0;
         mag_a  <= '0;
         mag_b  <= '0;
         acc    <= '0;
         count  <= '0;
         p_q    <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (Start) begin
                  sign_q <= A[tamanyo-1] ^ B[tamanyo-1];
                  mag_a  <= a_mag;
                  mag_b  <= b_mag;
                  acc    <= '0;
                  count  <= '0;
               end
            end
            CALC: begin
               if (mag_b[0]) begin
                  acc <= acc + addend;
               end
               mag_b <= mag_b >> 1;
               count <= count + 1'b1;
            end
            SIGN: begin
               // A zero magnitude never becomes negative zero
               p_q <= (sign_q && (acc != '0)) ? (~acc + 1'b1) : acc;
            end
            default: begin
            end
         endcase
      end
   end

   assign P = p_q;

endmodule

// File: tb/tb_multiplicador_secuencial.sv
// tb/tb_multiplicador_secuencial.sv - directed self-checking bench for multiplicador_secuencial
module tb_multiplicador_secuencial;
   import mult_pkg::*;

   localparam int N = MULT_WIDTH;

   logic           CLK = 1'b0;
   logic           RSTa;
   logic           Start;
   logic [N-1:0]   A;
   logic [N-1:0]   B;
   logic           Busy;
   logic           Done;
   logic [2*N-1:0] P;

   int tests = 0;
   int fails = 0;

   always #5 CLK = ~CLK;

   multiplicador_secuencial #(.tamanyo(N)) dut (
      .CLK   (CLK),
      .RSTa  (RSTa),
      .Start (Start),
      .A     (A),
      .B     (B),
      .Busy  (Busy),
      .Done  (Done),
      .P     (P)
   );

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      tests++;
      if (obs !== exp) begin
         fails++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
      end
   endtask

   // Edges from accept to Done
   function automatic int exp_lat(input logic [N-1:0] b);
`ifdef MULT_EARLY_EXIT_EN
      logic [N-1:0] m;
      int hi;
      m  = b[N-1] ? (~b + 1'b1) : b;
      hi = -1;
      for (int i = 0; i < N; i++) if (m[i]) hi = i;
      return hi + 1 + 2;
`else
      return (b === b) ? N + 2 : N + 2;
`endif
   endfunction

   // Called at a negedge; edge 0 is the next posedge (accept). Samples at negedge k
   // show the value seen by edge k.
   task automatic run_op(input logic [N-1:0] a, input logic [N-1:0] b,
                         input logic [2*N-1:0] exp_p, input string tag,
                         input int poke_edge, input int rst_edge, input bit start_at_done);
      int done_edge;
      int busy_cnt;
      int lat;
      done_edge = 0;
      busy_cnt  = 0;
      lat       = exp_lat(b);
      A = a;
      B = b;
      Start = 1'b1;
      @(posedge CLK);
      for (int k = 1; k <= 100; k++) begin
         @(negedge CLK);
         if (k == 1) Start = 1'b0;
         if (k == rst_edge) begin
            RSTa = 1'b1;
            #1;
            check({tag, " rst P"}, P, 64'd0);
            check({tag, " rst Done"}, 64'(Done), 64'd0);
            check({tag, " rst Busy"}, 64'(Busy), 64'd0);
            RSTa = 1'b0;
            return;
         end
         if (poke_edge != 0 && k == poke_edge) begin
            A = 32'd9;
            B = 32'd9;
            Start = 1'b1;
         end
         if (poke_edge != 0 && k == poke_edge + 1) Start = 1'b0;
         if (Done) begin
            done_edge = k;
            break;
         end
         if (Busy) busy_cnt++;
      end
      check({tag, " latency"}, 64'(done_edge), 64'(lat));
      check({tag, " busy cycles"}, 64'(busy_cnt), 64'(lat - 1));
      check({tag, " busy at done"}, 64'(Busy), 64'd0);
      check({tag, " P"}, P, exp_p);
      if (start_at_done) begin
         A = 32'd9;
         B = 32'd9;
         Start = 1'b1;
      end
      @(negedge CLK);
      check({tag, " done pulse"}, 64'(Done), 64'd0);
      check({tag, " idle after"}, 64'(Busy), 64'd0);
      check({tag, " P held"}, P, exp_p);
   endtask

   initial begin
      RSTa  = 1'b1;
      Start = 1'b0;
      A     = '0;
      B     = '0;
      #12;
      check("reset Busy", 64'(Busy), 64'd0);
      check("reset Done", 64'(Done), 64'd0);
      check("reset P", P, 64'd0);
      @(negedge CLK);
      RSTa = 1'b0;
      @(negedge CLK);

      run_op(32'd7,          32'd6,          64'h0000_0000_0000_002A, "7x6",      0, 0, 0);
      run_op(32'hFFFF_FFF9,  32'd6,          64'hFFFF_FFFF_FFFF_FFD6, "-7x6",     0, 0, 0);
      run_op(32'hFFFF_FFF9,  32'hFFFF_FFFA,  64'h0000_0000_0000_002A, "-7x-6",    0, 0, 0);
      run_op(32'h8000_0000,  32'h8000_0000,  64'h4000_0000_0000_0000, "min*min",  0, 0, 0);
      run_op(32'h8000_0000,  32'd1,          64'hFFFF_FFFF_8000_0000, "min*1",    0, 0, 0);
      run_op(32'h7FFF_FFFF,  32'h7FFF_FFFF,  64'h3FFF_FFFF_0000_0001, "max*max",  0, 0, 0);
      run_op(32'h0000_1234,  32'd0,          64'd0,                   "x*0",      0, 0, 0);
      run_op(32'hFFFF_FFFB,  32'd0,          64'd0,                   "-5x0",     0, 0, 0);
      run_op(32'd3,          32'd5,          64'd15,                  "3x5 busy", 10, 0, 1);
      run_op(32'd9,          32'd9,          64'd81,                  "9x9",      0, 0, 0);
      run_op(32'd3,          32'd5,          64'd0,                   "abort",    0, 12, 0);
      run_op(32'd2,          32'd2,          64'd4,                   "2x2",      0, 0, 0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
